// File: rtl/rmac_pkg.sv
// rmac_pkg: shared types and constants for the rmac operand feeder.
//   feeder_state_t  - sequencer FSM states
//   operand_pair_t  - one {weight, input} pair at the default operand width
//   Q_ONE           - 1.0 in the default Q(DEF_INT_BITS).(DEF_FRAC_BITS) format
package rmac_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_INT_BITS  = 12;
  localparam int DEF_FRAC_BITS = 20;

  localparam logic [DEF_WIDTH-1:0] Q_ONE = 1 << DEF_FRAC_BITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_t;

  // Weight sits in the upper half, matching the bank's {w, x} packing.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] w;
    logic [DEF_WIDTH-1:0] x;
  } operand_pair_t;

endpackage

// File: rtl/rmac_operand_bank.sv
// rmac_operand_bank: N-entry register file of {weight, input} pairs.
//   clk        in   clock, rising edge
//   i_wr_en    in   write strobe
//   i_wr_addr  in   write slot
//   i_wr_data  in   {w, x} pair to store
//   i_rd_addr  in   read slot
//   o_rd_data  out  {w, x} pair at i_rd_addr (combinational read)
// Contents are deliberately not reset.
module rmac_operand_bank
  import rmac_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   i_wr_en,
  input  logic [$clog2(N)-1:0]   i_wr_addr,
  input  logic [2*WIDTH-1:0]     i_wr_data,
  input  logic [$clog2(N)-1:0]   i_rd_addr,
  output logic [2*WIDTH-1:0]     o_rd_data
);

  logic [2*WIDTH-1:0] r_mem [N];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/rmac_feeder.sv
// rmac_feeder: buffers up to N operand pairs and streams them to rmac, one
// pair per cycle, then captures rmac's sum into result.
//   clk, rst_n        clock (rising) and synchronous active-low reset
//   wr_en/wr_addr     write {wr_w, wr_x} into a buffer slot (IDLE only)
//   start/len         stream slots 0..len-1 (1 <= len <= N, IDLE only)
//   busy              high from the cycle after an accepted start through
//                     the result_valid cycle
//   W/X/op_valid      operand stream; op_first/finished mark vector ends
//   sum_in            rmac sum, sampled SUM_LAT cycles after finished
//   result/           captured sum and its one-cycle update pulse
//   result_valid
//   o_dbg_state       current FSM state, for observation only
//
// Stream handshake: there is no back-pressure. Whenever op_valid is high,
// W/X carry a pair that rmac must consume in that same cycle; when op_valid
// is low, W, X, op_first and finished are all zero.
module rmac_feeder
  import rmac_pkg::*;
#(
  parameter int N         = 8,
  parameter int WIDTH     = DEF_WIDTH,
  parameter int INT_BITS  = DEF_INT_BITS,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int SUM_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [$clog2(N)-1:0]  wr_addr,
  input  logic [WIDTH-1:0]      wr_w,
  input  logic [WIDTH-1:0]      wr_x,
  input  logic                  start,
  input  logic [$clog2(N):0]    len,
  output logic                  busy,
  output logic [WIDTH-1:0]      W,
  output logic [WIDTH-1:0]      X,
  output logic                  op_valid,
  output logic                  op_first,
  output logic                  finished,
  input  logic [WIDTH-1:0]      sum_in,
  output logic [WIDTH-1:0]      result,
  output logic                  result_valid,
  output feeder_state_t         o_dbg_state
);

  localparam int ADDR_W   = $clog2(N);
  localparam int LEN_W    = ADDR_W + 1;
  localparam int LAT_W    = (SUM_LAT > 1) ? $clog2(SUM_LAT) : 1;
  localparam int LAT_LAST = (SUM_LAT > 0) ? SUM_LAT - 1 : 0;

  if (INT_BITS + FRAC_BITS != WIDTH) begin : g_bad_q_format
    $error("rmac_feeder: INT_BITS + FRAC_BITS must equal WIDTH");
  end

  feeder_state_t      r_state, w_state_next;
  logic [LEN_W-1:0]   r_k, w_k_next;
  logic [LEN_W-1:0]   r_len;
  logic [LAT_W-1:0]   r_lat, w_lat_next;
  logic [WIDTH-1:0]   r_w, r_x;
  logic               r_op_valid, r_busy, r_result_valid;
  logic [WIDTH-1:0]   r_result;

  logic               w_wr_ok, w_start_ok, w_last, w_capture, w_bypass;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [2*WIDTH-1:0] w_rd_pair, w_pair_next;

  assign w_wr_ok    = rst_n && wr_en && (r_state == ST_IDLE);
  assign w_start_ok = start && (r_state == ST_IDLE) &&
                      (len != '0) && (len <= LEN_W'(N));
  assign w_last     = (r_k == r_len - LEN_W'(1));

  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_lat_next   = r_lat;
    w_capture    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_next = ST_STREAM;
          w_k_next     = '0;
        end
      end
      ST_STREAM: begin
        if (w_last) begin
          w_k_next = '0;
          if (SUM_LAT == 0) begin
            // Zero-latency rmac: its sum is already valid in the finished cycle.
            w_capture    = 1'b1;
            w_state_next = ST_DONE;
          end else begin
            w_lat_next   = '0;
            w_state_next = ST_WAIT;
          end
        end else begin
          w_k_next = r_k + LEN_W'(1);
        end
      end
      ST_WAIT: begin
        if (r_lat == LAT_W'(LAT_LAST)) begin
          w_capture    = 1'b1;
          w_state_next = ST_DONE;
        end else begin
          w_lat_next = r_lat + LAT_W'(1);
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // The bank is read at the index the next cycle will present, so W/X can be
  // registered. A write in the same IDLE cycle as start is forwarded so the
  // first pair reflects the new data.
  assign w_rd_addr   = w_k_next[ADDR_W-1:0];
  assign w_bypass    = w_wr_ok && (wr_addr == w_rd_addr);
  assign w_pair_next = (w_state_next != ST_STREAM) ? '0 :
                       w_bypass ? {wr_w, wr_x} : w_rd_pair;

  rmac_operand_bank #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_bank (
    .clk       (clk),
    .i_wr_en   (w_wr_ok),
    .i_wr_addr (wr_addr),
    .i_wr_data ({wr_w, wr_x}),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_pair)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_k            <= '0;
      r_len          <= '0;
      r_lat          <= '0;
      r_w            <= '0;
      r_x            <= '0;
      r_op_valid     <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_k            <= w_k_next;
      r_lat          <= w_lat_next;
      r_w            <= w_pair_next[2*WIDTH-1:WIDTH];
      r_x            <= w_pair_next[WIDTH-1:0];
      r_op_valid     <= (w_state_next == ST_STREAM);
      r_busy         <= (w_state_next != ST_IDLE);
      r_result_valid <= (w_state_next == ST_DONE);
      if (w_start_ok) begin
        r_len <= len;
      end
      if (w_capture) begin
        r_result <= sum_in;
      end
    end
  end

  assign busy         = r_busy;
  assign W            = r_w;
  assign X            = r_x;
  assign op_valid     = r_op_valid;
  assign op_first     = (r_state == ST_STREAM) && (r_k == '0);
  assign finished     = (r_state == ST_STREAM) && w_last;
  assign result       = r_result;
  assign result_valid = r_result_valid;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_rmac_feeder.sv
// tb_rmac_feeder: two feeder instances (lane l has SUM_LAT = l) share one
// stimulus stream. Each lane drives its own behavioural Q12.20 rmac. A
// reference model predicts every operand beat, result and busy window from
// the buffer contents; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_rmac_feeder;
  import rmac_pkg::*;

  localparam int N     = 8;
  localparam int WIDTH = 32;
  localparam int FRAC  = 20;
  localparam int LANES = 2;

  typedef struct {
    int               cyc;
    logic             first;
    logic             fin;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] x;
  } op_exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_w, wr_x;
  logic             start;
  logic [3:0]       len;

  logic             d_busy [LANES];
  logic [WIDTH-1:0] d_w    [LANES];
  logic [WIDTH-1:0] d_x    [LANES];
  logic             d_opv  [LANES];
  logic             d_first[LANES];
  logic             d_fin  [LANES];
  logic [WIDTH-1:0] d_sum  [LANES];
  logic [WIDTH-1:0] d_res  [LANES];
  logic             d_rv   [LANES];
  feeder_state_t    d_state[LANES];

  function automatic logic [WIDTH-1:0] qmul(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return WIDTH'(p >>> FRAC);
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [WIDTH-1:0] rm_acc, rm_next;

    rmac_feeder #(
      .N(N), .WIDTH(WIDTH), .INT_BITS(12), .FRAC_BITS(FRAC), .SUM_LAT(l)
    ) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_w(wr_w), .wr_x(wr_x), .start(start), .len(len),
      .busy(d_busy[l]), .W(d_w[l]), .X(d_x[l]), .op_valid(d_opv[l]),
      .op_first(d_first[l]), .finished(d_fin[l]), .sum_in(d_sum[l]),
      .result(d_res[l]), .result_valid(d_rv[l]), .o_dbg_state(d_state[l])
    );

    // Behavioural rmac: multiply, accumulate, clear on op_first.
    assign rm_next = d_opv[l] ? ((d_first[l] ? '0 : rm_acc) + qmul(d_w[l], d_x[l]))
                              : rm_acc;
    always @(posedge clk) begin
      if (!rst_n) rm_acc <= '0;
      else        rm_acc <= rm_next;
    end
    assign d_sum[l] = (l == 0) ? rm_next : rm_acc;
  end

  // scoreboard state
  op_exp_t          exp_op_q    [LANES][$];
  logic [WIDTH-1:0] exp_q       [LANES][$];
  int               exp_rv_cyc_q[LANES][$];
  int               busy_start  [LANES];
  int               busy_end    [LANES];
  logic [WIDTH-1:0] hold        [LANES];
  operand_pair_t    mem         [LANES][N];
  int               n_checks = 0;
  int               n_pass   = 0;
  bit               mon_en   = 1'b0;

  task automatic chk(input string name, input int l,
                     input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s lane%0d cyc=%0d got=%h expected=%h", name, l, cyc, got, exp);
  endtask

  // monitor
  always @(negedge clk) begin
    if (mon_en) begin
      for (int l = 0; l < LANES; l++) begin
        logic             exp_v, exp_rv;
        op_exp_t          e;
        logic [WIDTH-1:0] r;
        int               tmp;
        exp_v = (exp_op_q[l].size() > 0) && (exp_op_q[l][0].cyc == cyc);
        chk("op_valid", l, 96'(d_opv[l]), 96'(exp_v));
        if (exp_v) begin
          e = exp_op_q[l].pop_front();
          chk("operands", l, 96'({d_first[l], d_fin[l], d_w[l], d_x[l]}),
              96'({e.first, e.fin, e.w, e.x}));
        end else begin
          chk("idle_outputs", l, 96'({d_first[l], d_fin[l], d_w[l], d_x[l]}), 96'(0));
        end
        exp_rv = (exp_rv_cyc_q[l].size() > 0) && (exp_rv_cyc_q[l][0] == cyc);
        chk("result_valid", l, 96'(d_rv[l]), 96'(exp_rv));
        if (exp_rv) begin
          tmp = exp_rv_cyc_q[l].pop_front();
          r   = exp_q[l].pop_front();
          chk("result", l, 96'(d_res[l]), 96'(r));
          hold[l] = r;
        end else begin
          chk("result_hold", l, 96'(d_res[l]), 96'(hold[l]));
        end
        chk("busy", l, 96'(d_busy[l]),
            96'((cyc >= busy_start[l]) && (cyc <= busy_end[l])));
      end
    end
  end

  // reference model: applied for the inputs held during cycle cyc
  task automatic model_apply(input bit we, input int addr, input logic [WIDTH-1:0] w,
                             input logic [WIDTH-1:0] x, input bit st, input int ln);
    for (int l = 0; l < LANES; l++) begin
      bit               idle;
      int               s;
      logic [WIDTH-1:0] acc;
      idle = (cyc > busy_end[l]);
      if (we && idle) mem[l][addr] = {w, x};
      if (st && idle && ln >= 1 && ln <= N) begin
        s   = cyc + 1;
        acc = '0;
        for (int k = 0; k < ln; k++) begin
          exp_op_q[l].push_back('{cyc: s + k, first: (k == 0), fin: (k == ln - 1),
                                  w: mem[l][k].w, x: mem[l][k].x});
          acc = acc + qmul(mem[l][k].w, mem[l][k].x);
        end
        exp_q[l].push_back(acc);
        exp_rv_cyc_q[l].push_back(s + ln + l);
        busy_start[l] = s;
        busy_end[l]   = s + ln + l;
      end
    end
  endtask

  // driver tasks
  task automatic drive(input bit we, input int addr, input logic [WIDTH-1:0] w,
                       input logic [WIDTH-1:0] x, input bit st, input int ln);
    @(posedge clk); #1;
    wr_en   = we;
    wr_addr = 3'(addr);
    wr_w    = w;
    wr_x    = x;
    start   = st;
    len     = 4'(ln);
    model_apply(we, addr, w, x, st, ln);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, '0, '0, 1'b0, 0);
  endtask

  function automatic logic [WIDTH-1:0] rnd_q();
    return WIDTH'($urandom_range(0, 32'h00FFFFFF)) - 32'h00800000;
  endfunction

  task automatic chk_reset();
    for (int l = 0; l < LANES; l++)
      chk("reset_values", l,
          96'({d_busy[l], d_opv[l], d_first[l], d_fin[l], d_rv[l], d_w[l], d_x[l]}), 96'(0));
    for (int l = 0; l < LANES; l++) chk("reset_result", l, 96'(d_res[l]), 96'(0));
  endtask

  // reset held for the current cycle only; pending expectations are dropped
  task automatic mid_reset();
    int c;
    @(posedge clk); #1;
    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0;
    c = cyc;
    @(negedge clk); #1;
    for (int l = 0; l < LANES; l++) begin
      exp_op_q[l].delete();
      exp_q[l].delete();
      exp_rv_cyc_q[l].delete();
      busy_end[l] = c;
      hold[l]     = '0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int l = 0; l < LANES; l++) begin
      busy_start[l] = 1;
      busy_end[l]   = 0;
      hold[l]       = '0;
    end
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_w = '0; wr_x = '0;
    start = 1'b0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset();
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // fill every slot so no run reads an unwritten entry
    for (int k = 0; k < N; k++) drive(1'b1, k, rnd_q(), rnd_q(), 1'b0, 0);

    // 1.0*1.0 + 0.5*1.0 + 0.75*1.0 = 2.25
    drive(1'b1, 0, 32'h00100000, 32'h00100000, 1'b0, 0);
    drive(1'b1, 1, 32'h00080000, 32'h00100000, 1'b0, 0);
    drive(1'b1, 2, 32'h000C0000, 32'h00100000, 1'b0, 0);
    drive(1'b0, 0, '0, '0, 1'b1, 3);
    idle_cycles(6);
    @(negedge clk);
    for (int l = 0; l < LANES; l++) chk("dot3_value", l, 96'(d_res[l]), 96'(32'h00240000));

    // single-pair vector
    drive(1'b0, 0, '0, '0, 1'b1, 1);
    idle_cycles(4);

    // write slot 0 in the start cycle
    drive(1'b1, 0, 32'h00200000, 32'h00100000, 1'b1, 2);
    idle_cycles(5);

    // ignored starts (len 0, len > N) and ignored traffic while busy
    drive(1'b0, 0, '0, '0, 1'b1, 0);
    drive(1'b0, 0, '0, '0, 1'b1, 9);
    drive(1'b0, 0, '0, '0, 1'b1, 4);
    drive(1'b1, 1, rnd_q(), rnd_q(), 1'b1, 2);
    drive(1'b1, 3, rnd_q(), rnd_q(), 1'b1, 5);
    idle_cycles(6);
    drive(1'b0, 0, '0, '0, 1'b1, 4);
    idle_cycles(7);

    // reset during the second streaming cycle, then a normal run
    drive(1'b0, 0, '0, '0, 1'b1, 5);
    drive(1'b0, 0, '0, '0, 1'b0, 0);
    mid_reset();
    drive(1'b0, 0, '0, '0, 1'b1, 3);
    idle_cycles(6);

    // full-depth vectors; lane 0 takes the back-to-back start ten cycles later
    for (int k = 0; k < N; k++) drive(1'b1, k, rnd_q(), rnd_q(), 1'b0, 0);
    drive(1'b0, 0, '0, '0, 1'b1, 8);
    idle_cycles(9);
    drive(1'b0, 0, '0, '0, 1'b1, 8);
    idle_cycles(12);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 2) == 0), int'($urandom_range(0, N - 1)), rnd_q(), rnd_q(),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, 10)));
    end
    idle_cycles(20);
    @(negedge clk);

    for (int l = 0; l < LANES; l++)
      chk("queues_drained", l,
          96'(exp_op_q[l].size() + exp_q[l].size() + exp_rv_cyc_q[l].size()), 96'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
